// File: rtl/clock_div_ctrl.sv
// Programmable clock divider: emits a 50% duty divided clock plus a one-cycle tick per toggle.
// Half-period changes arrive over a valid/ready handshake and are applied only at period ends.
module clock_div_ctrl #(
  parameter int COUNT_WIDTH  = 17,
  parameter int DEFAULT_HALF = 50000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   cfg_valid,
  input  logic [COUNT_WIDTH-1:0] cfg_half,
  output logic                   cfg_ready,
  output logic                   div_clock,
  output logic                   tick,
  output logic [COUNT_WIDTH-1:0] active_half,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [COUNT_WIDTH-1:0] DEF_HALF = COUNT_WIDTH'(DEFAULT_HALF);
  localparam logic [COUNT_WIDTH-1:0] ONE      = COUNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   div_q, div_d;
  logic                   tick_q, tick_d;
  logic [COUNT_WIDTH-1:0] active_q, active_d;
  logic                   pend_q, pend_d;
  logic [COUNT_WIDTH-1:0] pend_half_q, pend_half_d;

  logic last_cnt;
  logic fall;
  logic accept;

  assign last_cnt = (cnt_q == active_q - ONE);
  assign fall     = last_cnt && div_q;
  assign accept   = cfg_valid && !pend_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    tick_d      = 1'b0;
    active_d    = active_q;
    pend_d      = pend_q;
    pend_half_d = pend_half_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        div_d = 1'b0;
        if (pend_q) begin
          active_d = pend_half_q;
          pend_d   = 1'b0;
        end
        if (enable) state_d = RUN;
      end
      RUN, STOP: begin
        if (last_cnt) begin
          cnt_d  = '0;
          div_d  = !div_q;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
        // A pending ratio only lands at the end of a full period, so no runt phases.
        if (fall && pend_q) begin
          active_d = pend_half_q;
          pend_d   = 1'b0;
        end
        if (state_q == RUN) begin
          if (!enable) begin
            if (div_q) begin
              state_d = fall ? IDLE : STOP;
            end else begin
              // Low phase may be cut short; a high phase never is.
              state_d = IDLE;
              cnt_d   = '0;
              div_d   = 1'b0;
              tick_d  = 1'b0;
            end
          end
        end else if (fall) begin
          state_d = enable ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Acceptance is gated by the registered flag, so it never collides with an apply.
    if (accept) begin
      pend_d      = 1'b1;
      pend_half_d = (cfg_half == '0) ? ONE : cfg_half;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_q       <= 1'b0;
      tick_q      <= 1'b0;
      active_q    <= DEF_HALF;
      pend_q      <= 1'b0;
      pend_half_q <= DEF_HALF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      tick_q      <= tick_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_half_q <= pend_half_d;
    end
  end

  assign cfg_ready   = !pend_q;
  assign div_clock   = div_q;
  assign tick        = tick_q;
  assign active_half = active_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_clock_div_ctrl.sv
// Scoreboard bench for clock_div_ctrl: per-cycle expected output vectors are queued as
// stimulus is driven and compared against {div_clock, tick, busy, cfg_ready, active_half}.
module tb_clock_div_ctrl;
  localparam int W   = 17;
  localparam int DEF = 3;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         cfg_valid;
  logic [W-1:0] cfg_half;
  logic         cfg_ready;
  logic         div_clock;
  logic         tick;
  logic [W-1:0] active_half;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [W+3:0] exp_q[$];

  clock_div_ctrl #(.COUNT_WIDTH(W), .DEFAULT_HALF(DEF)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_half   (cfg_half),
    .cfg_ready  (cfg_ready),
    .div_clock  (div_clock),
    .tick       (tick),
    .active_half(active_half),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [W+3:0] mk(input logic d, input logic t, input logic b,
                                      input logic r, input int h);
    return {d, t, b, r, W'(h)};
  endfunction

  // Expected output j edges after a period start: toggles every h edges, tick on each toggle.
  function automatic logic [W+3:0] run_exp(input int j, input int h, input bit first,
                                           input logic r, input int act);
    logic d, t;
    d = ((j / h) % 2) != 0;
    t = ((j % h) == 0) && ((j > 0) || first);
    return mk(d, t, 1'b1, r, act);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [W+3:0] got, want;
    enable = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    for (int i = 0; i < 3; i++) begin
      reset = (i < 2);
      exp_q.push_back(mk(0, 0, 0, 1, DEF));
      step();
      got = {div_clock, tick, busy, cfg_ready, active_half};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset i=%0d: got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_run();
    logic [W+3:0] got, want;
    for (int j = 0; j < 20; j++) begin
      enable = (j < 19);
      exp_q.push_back((j < 19) ? run_exp(j, 3, 1'b0, 1'b1, 3) : mk(0, 0, 0, 1, 3));
      step();
      got = {div_clock, tick, busy, cfg_ready, active_half};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL run j=%0d: got %h expected %h", j, got, want);
      end
    end
  endtask

  task automatic test_cfg_idle();
    logic [W+3:0] got, want;
    for (int i = 0; i < 24; i++) begin
      cfg_valid = (i == 0);
      cfg_half  = 5;
      enable    = (i >= 2) && (i < 23);
      if (i == 0)       exp_q.push_back(mk(0, 0, 0, 0, 3));
      else if (i == 1)  exp_q.push_back(mk(0, 0, 0, 1, 5));
      else if (i < 23)  exp_q.push_back(run_exp(i - 2, 5, 1'b0, 1'b1, 5));
      else              exp_q.push_back(mk(0, 0, 0, 1, 5));
      step();
      got = {div_clock, tick, busy, cfg_ready, active_half};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cfg_idle i=%0d: got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_cfg_run();
    logic [W+3:0] got, want;
    for (int i = 0; i < 18; i++) begin
      int j;
      j = i - 2;
      if (i < 2) begin
        enable = 1'b0; cfg_valid = (i == 0); cfg_half = 3;
        exp_q.push_back((i == 0) ? mk(0, 0, 0, 0, 5) : mk(0, 0, 0, 1, 3));
      end else begin
        enable    = (j < 15);
        cfg_valid = (j == 4) || (j == 5);
        cfg_half  = (j == 4) ? 2 : 7;
        if (j <= 3)      exp_q.push_back(run_exp(j, 3, 1'b0, 1'b1, 3));
        else if (j <= 5) exp_q.push_back(mk(1, 0, 1, 0, 3));
        else if (j < 15) exp_q.push_back(run_exp(j - 6, 2, 1'b1, 1'b1, 2));
        else             exp_q.push_back(mk(0, 0, 0, 1, 2));
      end
      step();
      got = {div_clock, tick, busy, cfg_ready, active_half};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cfg_run i=%0d: got %h expected %h", i, got, want);
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_stop();
    logic [W+3:0] got, want;
    for (int i = 0; i < 11; i++) begin
      int j;
      j = i - 2;
      if (i < 2) begin
        enable = 1'b0; cfg_valid = (i == 0); cfg_half = 3;
        exp_q.push_back((i == 0) ? mk(0, 0, 0, 0, 2) : mk(0, 0, 0, 1, 3));
      end else begin
        cfg_valid = 1'b0;
        enable    = (j < 5);
        if (j <= 5)      exp_q.push_back(run_exp(j, 3, 1'b0, 1'b1, 3));
        else if (j == 6) exp_q.push_back(mk(0, 1, 0, 1, 3));
        else             exp_q.push_back(mk(0, 0, 0, 1, 3));
      end
      step();
      got = {div_clock, tick, busy, cfg_ready, active_half};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL stop i=%0d: got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_zero_half();
    logic [W+3:0] got, want;
    for (int i = 0; i < 10; i++) begin
      int j;
      j = i - 2;
      if (i < 2) begin
        enable = 1'b0; cfg_valid = (i == 0); cfg_half = 0;
        exp_q.push_back((i == 0) ? mk(0, 0, 0, 0, 3) : mk(0, 0, 0, 1, 1));
      end else begin
        cfg_valid = 1'b0;
        enable    = (j < 7);
        exp_q.push_back((j < 7) ? run_exp(j, 1, 1'b0, 1'b1, 1) : mk(0, 0, 0, 1, 1));
      end
      step();
      got = {div_clock, tick, busy, cfg_ready, active_half};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL zero_half i=%0d: got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W+3:0] got, want;
    for (int i = 0; i < 20; i++) begin
      int j;
      j = i - 2;
      if (i < 2) begin
        enable = 1'b0; cfg_valid = (i == 0); cfg_half = 3;
        exp_q.push_back((i == 0) ? mk(0, 0, 0, 0, 1) : mk(0, 0, 0, 1, 3));
      end else begin
        enable    = (j < 17);
        cfg_valid = (j == 6);
        cfg_half  = 2;
        if (j < 6)       exp_q.push_back(run_exp(j, 3, 1'b0, 1'b1, 3));
        else if (j < 12) exp_q.push_back(run_exp(j, 3, 1'b0, 1'b0, 3));
        else if (j < 17) exp_q.push_back(run_exp(j - 12, 2, 1'b1, 1'b1, 2));
        else             exp_q.push_back(mk(0, 0, 0, 1, 2));
      end
      step();
      got = {div_clock, tick, busy, cfg_ready, active_half};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL back_to_back i=%0d: got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W+3:0] got, want;
    for (int i = 0; i < 11; i++) begin
      int j;
      j = i - 2;
      if (i < 2) begin
        reset = 1'b0; enable = 1'b0; cfg_valid = (i == 0); cfg_half = 4;
        exp_q.push_back((i == 0) ? mk(0, 0, 0, 0, 2) : mk(0, 0, 0, 1, 4));
      end else begin
        enable    = (j <= 7);
        reset     = (j == 7);
        cfg_valid = (j == 6);
        cfg_half  = 9;
        if (j <= 5)      exp_q.push_back(run_exp(j, 4, 1'b0, 1'b1, 4));
        else if (j == 6) exp_q.push_back(run_exp(j, 4, 1'b0, 1'b0, 4));
        else             exp_q.push_back(mk(0, 0, 0, 1, DEF));
      end
      step();
      got = {div_clock, tick, busy, cfg_ready, active_half};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid i=%0d: got %h expected %h", i, got, want);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    test_reset();
    test_run();
    test_cfg_idle();
    test_cfg_run();
    test_stop();
    test_zero_half();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
